i2c_sequencer: RTL and testbench

I2C_SEQUENCER -- requirements
Module: i2c_sequencer

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_sequencer_poll_timer.sv | 27 ++
 rtl/i2c_sequencer.sv | 161 ++++++++++++++++
 tb/tb_i2c_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C sequencer: FSM state encoding, register-bus
// address codes of the I2C master core, and the burst register helper.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SLV,
    RW,
    REG,
    DATA,
    EN_ON,
    WAIT,
    EN_OFF,
    READ
  } state_t;

  localparam logic [2:0] ENABLE           = 3'd0;
  localparam logic [2:0] SLAVE_ADDRESS    = 3'd1;
  localparam logic [2:0] READ_WRITE       = 3'd2;
  localparam logic [2:0] REGISTER_ADDRESS = 3'd3;
  localparam logic [2:0] DATA_IN          = 3'd4;
  localparam logic [2:0] DATA_OUT         = 3'd5;

  // Register numbers wrap modulo 256 through the natural 8-bit add.
  function automatic logic [7:0] burst_reg(input logic [7:0] base, input logic [2:0] idx);
    return base + {5'b0, idx};
  endfunction

endpackage

// File: rtl/i2c_sequencer_poll_timer.sv
// Free-running poll counter; tick is high for the one cycle the count sits at
// POLL_PERIOD-1, after which it wraps to zero.
module poll_timer #(
  parameter int POLL_PERIOD = 1000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = $clog2(POLL_PERIOD);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(POLL_PERIOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/i2c_sequencer.sv
// Drives an I2C master core over its register bus: one wake write after reset,
// then periodic bursts of consecutive register reads presented as a byte stream.
module i2c_sequencer
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h68,
  parameter logic [7:0] WAKE_REG    = 8'h6B,
  parameter logic [7:0] WAKE_VAL    = 8'h00,
  parameter logic [7:0] BASE_REG    = 8'h3B,
  parameter int         NUM_REGS    = 6,
  parameter int         XFER_CYCLES = 4000,
  parameter int         POLL_PERIOD = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic [2:0] bus_address,
  output logic [7:0] bus_write_data,
  output logic       bus_we,
  output logic       bus_re,
  input  logic [7:0] bus_read_data,
  output logic       out_valid,
  output logic [2:0] out_index,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       overrun,
  output logic       init_done
);

  localparam int WAIT_W = $clog2(XFER_CYCLES + 1);

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [2:0]        byte_idx;
  logic              xact_wr;
  logic              tick;
  logic              start_wake;
  logic              start_burst;
  logic              last_byte;
  logic              wait_done;

  poll_timer #(.POLL_PERIOD(POLL_PERIOD)) u_poll_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign busy        = (state != IDLE);
  assign start_wake  = (state == IDLE) && !init_done;
  assign start_burst = (state == IDLE) && init_done && tick && run;
  assign last_byte   = (byte_idx == 3'(NUM_REGS - 1));
  assign wait_done   = (wait_cnt == WAIT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_wake || start_burst) state_nxt = SLV;
      SLV:     state_nxt = RW;
      RW:      state_nxt = REG;
      REG:     state_nxt = xact_wr ? DATA : EN_ON;
      DATA:    state_nxt = EN_ON;
      EN_ON:   state_nxt = WAIT;
      WAIT:    if (wait_done) state_nxt = EN_OFF;
      EN_OFF:  state_nxt = xact_wr ? IDLE : READ;
      READ:    state_nxt = last_byte ? IDLE : SLV;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus_we         = 1'b0;
    bus_re         = 1'b0;
    bus_address    = ENABLE;
    bus_write_data = 8'h00;
    case (state)
      SLV: begin
        bus_we         = 1'b1;
        bus_address    = SLAVE_ADDRESS;
        bus_write_data = {1'b0, SLAVE_ADDR};
      end
      RW: begin
        bus_we         = 1'b1;
        bus_address    = READ_WRITE;
        bus_write_data = {7'b0, ~xact_wr};
      end
      REG: begin
        bus_we         = 1'b1;
        bus_address    = REGISTER_ADDRESS;
        bus_write_data = xact_wr ? WAKE_REG : burst_reg(BASE_REG, byte_idx);
      end
      DATA: begin
        bus_we         = 1'b1;
        bus_address    = DATA_IN;
        bus_write_data = WAKE_VAL;
      end
      EN_ON: begin
        bus_we         = 1'b1;
        bus_write_data = 8'h01;
      end
      EN_OFF: begin
        bus_we         = 1'b1;
      end
      READ: begin
        bus_re         = 1'b1;
        bus_address    = DATA_OUT;
      end
      default: ;
    endcase
  end

  // Ticks are dropped while a transaction is in flight or before the wake write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= '0;
      byte_idx  <= '0;
      xact_wr   <= 1'b0;
      init_done <= 1'b0;
      overrun   <= 1'b0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= (state == READ);
      if (state == READ) begin
        out_index <= byte_idx;
        out_data  <= bus_read_data;
      end
      if (start_wake) begin
        xact_wr <= 1'b1;
      end else if (start_burst) begin
        xact_wr <= 1'b0;
      end
      if (start_burst) begin
        byte_idx <= '0;
      end else if (state == READ && !last_byte) begin
        byte_idx <= byte_idx + 3'd1;
      end
      if (state == EN_ON) begin
        wait_cnt <= WAIT_W'(XFER_CYCLES);
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - WAIT_W'(1);
      end
      if (state == EN_OFF && xact_wr) begin
        init_done <= 1'b1;
      end
      if (tick && run && (busy || !init_done)) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_sequencer.sv
// Three sequencer instances (baseline, overlapping ticks, wrapping register
// range) checked cycle-exactly against a transaction-timeline scoreboard.
module tb_i2c_sequencer;

  localparam int        NI    = 3;
  localparam int        XFER  = 4;
  localparam logic [6:0] SADDR = 7'h68;
  localparam logic [7:0] WREG  = 8'h6B;
  localparam logic [7:0] WVAL  = 8'h00;

  function automatic int poll_of(int k);
    return (k == 1) ? 30 : (k == 2) ? 50 : 100;
  endfunction
  function automatic int nregs_of(int k);
    return (k == 2) ? 3 : 6;
  endfunction
  function automatic logic [7:0] base_of(int k);
    return (k == 2) ? 8'hFE : 8'h3B;
  endfunction

  typedef struct {
    int         cyc;
    bit         re;
    logic [2:0] addr;
    logic [7:0] data;
  } bus_ev_t;

  typedef struct {
    int         cyc;
    logic [2:0] idx;
    logic [7:0] data;
  } byte_ev_t;

  function automatic bus_ev_t ev(int c, bit r, logic [2:0] a, logic [7:0] d);
    bus_ev_t e;
    e.cyc = c; e.re = r; e.addr = a; e.data = d;
    return e;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  int   cyc;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] rd_mem [256];

  logic [2:0] addr  [NI];
  logic [7:0] wdata [NI];
  logic       we    [NI];
  logic       re    [NI];
  logic [7:0] rdata [NI];
  logic       ov    [NI];
  logic [2:0] oidx  [NI];
  logic [7:0] odata [NI];
  logic       bsy   [NI];
  logic       ovr   [NI];
  logic       idone [NI];

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  for (genvar g = 0; g < NI; g++) begin : g_dut
    i2c_sequencer #(
      .SLAVE_ADDR  (SADDR),
      .WAKE_REG    (WREG),
      .WAKE_VAL    (WVAL),
      .BASE_REG    (base_of(g)),
      .NUM_REGS    (nregs_of(g)),
      .XFER_CYCLES (XFER),
      .POLL_PERIOD (poll_of(g))
    ) dut (
      .clk            (clk),
      .rst            (rst),
      .run            (run),
      .bus_address    (addr[g]),
      .bus_write_data (wdata[g]),
      .bus_we         (we[g]),
      .bus_re         (re[g]),
      .bus_read_data  (rdata[g]),
      .out_valid      (ov[g]),
      .out_index      (oidx[g]),
      .out_data       (odata[g]),
      .busy           (bsy[g]),
      .overrun        (ovr[g]),
      .init_done      (idone[g])
    );
    // Slave data is only meaningful while the DATA_OUT register is being read.
    assign rdata[g] = (re[g] && addr[g] == 3'd5) ? rd_mem[cyc[7:0]] : 8'h00;
  end

  // Reference timeline: transactions are laid out as cycle-stamped events.
  bus_ev_t  bq [NI][$];
  byte_ev_t yq [NI][$];
  int       free_at [NI];
  int       init_at [NI];
  bit       woke    [NI];
  bit       ovr_m   [NI];

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        bq[k].delete();
        yq[k].delete();
        woke[k]    = 1'b0;
        ovr_m[k]   = 1'b0;
        free_at[k] = 0;
        init_at[k] = 32'h7fff_ffff;
      end else begin
        if (!woke[k]) begin
          woke[k] = 1'b1;
          bq[k].push_back(ev(cyc + 1, 1'b0, 3'd1, {1'b0, SADDR}));
          bq[k].push_back(ev(cyc + 2, 1'b0, 3'd2, 8'h00));
          bq[k].push_back(ev(cyc + 3, 1'b0, 3'd3, WREG));
          bq[k].push_back(ev(cyc + 4, 1'b0, 3'd4, WVAL));
          bq[k].push_back(ev(cyc + 5, 1'b0, 3'd0, 8'h01));
          bq[k].push_back(ev(cyc + 6 + XFER, 1'b0, 3'd0, 8'h00));
          free_at[k] = cyc + 7 + XFER;
          init_at[k] = cyc + 7 + XFER;
        end
        if (run && (cyc % poll_of(k)) == poll_of(k) - 1) begin
          if (cyc >= free_at[k] && cyc >= init_at[k]) begin
            for (int i = 0; i < nregs_of(k); i++) begin
              int b;
              byte_ev_t y;
              b = cyc + i * (6 + XFER);
              bq[k].push_back(ev(b + 1, 1'b0, 3'd1, {1'b0, SADDR}));
              bq[k].push_back(ev(b + 2, 1'b0, 3'd2, 8'h01));
              bq[k].push_back(ev(b + 3, 1'b0, 3'd3, 8'(base_of(k) + 8'(i))));
              bq[k].push_back(ev(b + 4, 1'b0, 3'd0, 8'h01));
              bq[k].push_back(ev(b + 5 + XFER, 1'b0, 3'd0, 8'h00));
              bq[k].push_back(ev(b + 6 + XFER, 1'b1, 3'd5, 8'h00));
              y.cyc  = b + 7 + XFER;
              y.idx  = 3'(i);
              y.data = rd_mem[8'(b + 6 + XFER)];
              yq[k].push_back(y);
            end
            free_at[k] = cyc + nregs_of(k) * (6 + XFER) + 1;
          end else begin
            ovr_m[k] = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: compares whatever the DUTs present against the timeline.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        checks++;
        if ({addr[k], wdata[k], we[k], re[k], ov[k], oidx[k], odata[k],
             bsy[k], ovr[k], idone[k]} !== 28'h0) begin
          failures++;
          $display("FAIL reset_zero dut%0d: got addr=%0d wdata=%h we=%0b re=%0b ov=%0b idx=%0d data=%h busy=%0b ovr=%0b init=%0b, required all zero",
                   k, addr[k], wdata[k], we[k], re[k], ov[k], oidx[k], odata[k], bsy[k], ovr[k], idone[k]);
        end
      end else begin
        bit exp_b;
        bit exp_y;
        checks++;
        if (ovr[k] !== ovr_m[k] || idone[k] !== (cyc >= init_at[k]) || bsy[k] !== (cyc < free_at[k])) begin
          failures++;
          $display("FAIL flags dut%0d cyc=%0d: got overrun=%0b init_done=%0b busy=%0b, required %0b %0b %0b",
                   k, cyc, ovr[k], idone[k], bsy[k], ovr_m[k], cyc >= init_at[k], cyc < free_at[k]);
        end
        exp_b = (bq[k].size() > 0) && (bq[k][0].cyc == cyc);
        if (we[k] || re[k] || exp_b) begin
          checks++;
          if (!exp_b) begin
            failures++;
            $display("FAIL bus_unexpected dut%0d cyc=%0d: got we=%0b re=%0b addr=%0d data=%h, required no access",
                     k, cyc, we[k], re[k], addr[k], wdata[k]);
          end else begin
            bus_ev_t e;
            e = bq[k].pop_front();
            if (we[k] !== !e.re || re[k] !== e.re || addr[k] !== e.addr || wdata[k] !== e.data) begin
              failures++;
              $display("FAIL bus_access dut%0d cyc=%0d: got we=%0b re=%0b addr=%0d data=%h, required we=%0b re=%0b addr=%0d data=%h",
                       k, cyc, we[k], re[k], addr[k], wdata[k], !e.re, e.re, e.addr, e.data);
            end
          end
        end
        exp_y = (yq[k].size() > 0) && (yq[k][0].cyc == cyc);
        if (ov[k] || exp_y) begin
          checks++;
          if (!exp_y) begin
            failures++;
            $display("FAIL byte_unexpected dut%0d cyc=%0d: got idx=%0d data=%h, required no out_valid",
                     k, cyc, oidx[k], odata[k]);
          end else begin
            byte_ev_t y;
            y = yq[k].pop_front();
            if (ov[k] !== 1'b1 || oidx[k] !== y.idx || odata[k] !== y.data) begin
              failures++;
              $display("FAIL byte_out dut%0d cyc=%0d: got valid=%0b idx=%0d data=%h, required valid=1 idx=%0d data=%h",
                       k, cyc, ov[k], oidx[k], odata[k], y.idx, y.data);
            end
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) rd_mem[i] = 8'($urandom);
    rst = 1'b1;
    run = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    run = 1'b1;
    // Drop run during byte 2 of the first baseline burst, resume later.
    repeat (122) @(posedge clk);
    #2 run = 1'b0;
    repeat (228) @(posedge clk);
    #2 run = 1'b1;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      #2 if ($urandom_range(0, 99) < 3) run = ~run;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    run = 1'b1;
    // Reset inside the wake write's WAIT window.
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    // Reset inside the WAIT window of the first burst read.
    repeat (106) @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (400) @(posedge clk);
    #2 run = 1'b0;
    repeat (150) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
